i2c_config_sequencer: RTL and testbench
=======================================

Name: i2c_config_sequencer

Overview:
- Walks a table of NUM_REGS 24-bit I2C write words (slave address, sub-address, data) from a synchronous lookup ROM and hands them one at a time to the 3-byte I2C write controller.
- For each word: fetch, load, pulse GO, wait for end-of-transfer, check ACK, retry or advance.
- Sits between system start-up logic (codec/sensor init) and the I2C write datapath.
- Reports done, or error with the failing table index.

Parameters:
- NUM_REGS, 16, number of table entries (1..2**IDX_W).
- IDX_W, 4, width of table index / lut_addr.
- MAX_RETRY, 3, re-attempts per entry after a NACK or timeout before declaring error.
- GAP_CYCLES, 16, idle CLK cycles between transfers (bus free time), >=1.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_END before treating the transfer as failed, >=32.

Ports:
- CLK  in  1  system clock; also the I2C bit clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  begin sequence; sampled only in IDLE, DONE, ERROR.
- lut_addr  out  IDX_W  ROM address, registered.
- lut_data  in  24  ROM word, valid one cycle after lut_addr changes.
- i2c_data  out  24  word presented to the I2C shifter, registered, stable from LOAD until the next LOAD.
- i2c_go  out  1  one-cycle GO pulse to the I2C controller.
- i2c_end  in  1  one-cycle pulse: transfer finished (controller END state).
- i2c_nack  in  1  any of the three ACK bits high; valid when i2c_end=1.
- busy  out  1  high in every state except IDLE, DONE, ERROR.
- done  out  1  sticky; all entries acknowledged.
- error  out  1  sticky; retries exhausted.
- err_index  out  IDX_W  index of the failing entry; valid while error=1.

Behaviour:
- Reset: state=IDLE; lut_addr=0, i2c_data=0, i2c_go=0, busy=0, done=0, error=0, err_index=0; index, retry, gap and timeout counters are 0.
  - Reset mid-transfer aborts immediately.
  - The I2C controller shares the same reset.
- States:
  - IDLE: start -> FETCH, index=0, retry=0.
  - FETCH: lut_addr=index; 1 cycle -> LOAD.
  - LOAD: i2c_data<=lut_data -> GO.
  - GO: i2c_go=1 for exactly this cycle -> WAIT_END, timeout counter=0.
  - WAIT_END: on i2c_end -> CHECK, latching i2c_nack. If the timeout counter reaches TIMEOUT_CYCLES-1 without i2c_end -> CHECK with failure forced.
  - CHECK, success: retry=0.
    - If index==NUM_REGS-1 -> DONE (no gap).
    - Otherwise index+1 -> GAP.
  - CHECK, failure:
    - If retry<MAX_RETRY: retry+1 -> GAP, same index.
    - Otherwise err_index=index -> ERROR.
  - GAP: count GAP_CYCLES cycles -> FETCH.
  - DONE / ERROR: hold outputs. start -> clear done/error, index=0, retry=0 -> FETCH.
- Latency: start sampled at edge N -> i2c_go high between edges N+3 and N+4.
- start while busy=1 is ignored; no queueing.
- i2c_end outside WAIT_END is ignored.
- i2c_end in the same cycle as the timeout expiry: i2c_end wins and i2c_nack is used.
- Total attempts per entry = MAX_RETRY+1.
- Index never wraps: the DONE decision is taken on index==NUM_REGS-1 before incrementing.
- i2c_go is never asserted twice without an intervening i2c_end or timeout.
- Counters are sized with $clog2, with no overflow: the gap counter holds up to GAP_CYCLES-1 and the timeout counter up to TIMEOUT_CYCLES-1.

Decomposition:
- Shared package i2c_pkg:
  - state encoding constants (IDLE, FETCH, LOAD, GO, WAIT_END, CHECK, GAP, DONE, ERROR).
  - I2C word width 24.
  - byte field offsets (addr [23:16], sub [15:8], data [7:0]).
- One natural sub-module: i2c_config_rom, a synchronous NUM_REGS x 24 table with 1-cycle read latency. It is instantiated beside this block, not inside it, so the table can be swapped per target device.

Test Plan:
- NUM_REGS=4, ROM words 0x34_00_1F, 0x34_02_17, 0x34_04_79, 0x34_06_79; bench model always ACKs (i2c_nack=0, i2c_end 30 cycles after go) -> exactly 4 i2c_go pulses; i2c_data matches each ROM word in order; done=1, busy=0, error=0.
- Entry 1 NACKed once, then ACKed -> 5 go pulses; entry 1 issued twice with the same word; adjacent go pulses separated by >= GAP_CYCLES+3 cycles; done=1.
- Entry 2 always NACKed, MAX_RETRY=3 -> 4 attempts on entry 2, then error=1, err_index=2, done=0; no further go pulses; entry 3 never issued.
- Model never asserts i2c_end -> 4 timeouts of 64 cycles each on entry 0 -> error=1, err_index=0.
- Assert reset in WAIT_END of entry 1 -> next cycle: all outputs 0, state IDLE. A following start restarts from lut_addr=0.
- start pulsed while busy -> ignored. start after done -> done clears, sequence reruns with 4 pulses. Also check i2c_go rises exactly 3 edges after start is sampled.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C configuration path: sequencer state
// encoding, the 24-bit write word layout and the default register table.
package i2c_pkg;

  localparam int I2C_WORD_W = 24;

  // Byte fields inside one write word.
  localparam int ADDR_LSB = 16;
  localparam int SUB_LSB  = 8;
  localparam int DATA_LSB = 0;

  typedef logic [I2C_WORD_W-1:0] i2c_word_t;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_LOAD     = 4'd2,
    S_GO       = 4'd3,
    S_WAIT_END = 4'd4,
    S_CHECK    = 4'd5,
    S_GAP      = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } state_e;

  function automatic i2c_word_t make_word(input logic [7:0] addr,
                                          input logic [7:0] sub,
                                          input logic [7:0] data);
    i2c_word_t w;
    w = '0;
    w[ADDR_LSB +: 8] = addr;
    w[SUB_LSB  +: 8] = sub;
    w[DATA_LSB +: 8] = data;
    return w;
  endfunction

  // Default codec init table; entries beyond the list read as zero.
  function automatic i2c_word_t default_table(input int idx);
    i2c_word_t w;
    case (idx)
      0:       w = make_word(8'h34, 8'h00, 8'h1F);
      1:       w = make_word(8'h34, 8'h02, 8'h17);
      2:       w = make_word(8'h34, 8'h04, 8'h79);
      3:       w = make_word(8'h34, 8'h06, 8'h79);
      4:       w = make_word(8'h34, 8'h08, 8'h12);
      5:       w = make_word(8'h34, 8'h0A, 8'h06);
      6:       w = make_word(8'h34, 8'h0C, 8'h00);
      7:       w = make_word(8'h34, 8'h0E, 8'h01);
      8:       w = make_word(8'h34, 8'h10, 8'h02);
      9:       w = make_word(8'h34, 8'h12, 8'h01);
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// Synchronous NUM_REGS x 24 register table, one cycle read latency.
// Lives beside the sequencer so each target can supply its own table.
module i2c_config_rom
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                  CLK,
  input  logic [IDX_W-1:0]      addr,
  output logic [I2C_WORD_W-1:0] data
);

  i2c_word_t data_d;
  i2c_word_t data_q;

  // Table lookup; addresses past the populated range read as zero.
  always_comb begin
    data_d = '0;
    if (int'(addr) < NUM_REGS) begin
      data_d = default_table(int'(addr));
    end
  end

  // Registered read port.
  always_ff @(posedge CLK) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the register table and hands each word to the 3-byte I2C write
// controller, retrying NACKed or timed-out transfers and reporting
// done, or error with the failing index.
//
// Controller handshake: i2c_go is a single-cycle request that is only
// raised while no transfer is outstanding; the controller answers with a
// single-cycle i2c_end, qualified by i2c_nack in that same cycle. An
// i2c_end that arrives while no transfer is outstanding is ignored, and a
// missing i2c_end is closed out by the timeout as a failed transfer.
module i2c_config_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int IDX_W          = 4,
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  output logic [IDX_W-1:0]      lut_addr,
  input  logic [I2C_WORD_W-1:0] lut_data,
  output logic [I2C_WORD_W-1:0] i2c_data,
  output logic                  i2c_go,
  input  logic                  i2c_end,
  input  logic                  i2c_nack,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_index,
  output state_e                dbg_state
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e             state_d,     state_q;
  logic [IDX_W-1:0]   idx_d,       idx_q;
  logic [RETRY_W-1:0] retry_d,     retry_q;
  logic [GAP_W-1:0]   gap_d,       gap_q;
  logic [TMO_W-1:0]   tmo_d,       tmo_q;
  logic               fail_d,      fail_q;
  logic [IDX_W-1:0]   lut_addr_d,  lut_addr_q;
  i2c_word_t          i2c_data_d,  i2c_data_q;
  logic               i2c_go_d,    i2c_go_q;
  logic               busy_d,      busy_q;
  logic               done_d,      done_q;
  logic               error_d,     error_q;
  logic [IDX_W-1:0]   err_index_d, err_index_q;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    fail_d      = fail_q;
    lut_addr_d  = lut_addr_q;
    i2c_data_d  = i2c_data_q;
    err_index_d = err_index_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        i2c_data_d = lut_data;
        state_d    = S_GO;
      end
      S_GO: begin
        tmo_d   = '0;
        state_d = S_WAIT_END;
      end
      S_WAIT_END: begin
        // A real end beats a timeout expiring in the same cycle.
        if (i2c_end) begin
          fail_d  = i2c_nack;
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          fail_d  = 1'b1;
          state_d = S_CHECK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (!fail_q) begin
          retry_d = '0;
          // Decide DONE before incrementing so the index never wraps.
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          err_index_d = idx_q;
          state_d     = S_ERROR;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_FETCH;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The ROM address is registered on entry to FETCH so the word is
    // ready at the ROM output by the time LOAD samples it.
    if (state_d == S_FETCH) begin
      lut_addr_d = idx_d;
    end

    i2c_go_d = (state_q == S_GO);
    busy_d   = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERROR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      fail_q      <= 1'b0;
      lut_addr_q  <= '0;
      i2c_data_q  <= '0;
      i2c_go_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      fail_q      <= fail_d;
      lut_addr_q  <= lut_addr_d;
      i2c_data_q  <= i2c_data_d;
      i2c_go_q    <= i2c_go_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
    end
  end

  assign lut_addr  = lut_addr_q;
  assign i2c_data  = i2c_data_q;
  assign i2c_go    = i2c_go_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer with the table ROM beside it and a
// behavioural I2C controller that ACKs, NACKs or stays silent per entry.
module tb_i2c_config_sequencer;
  import i2c_pkg::*;

  localparam int NUM_REGS       = 4;
  localparam int IDX_W          = 4;
  localparam int MAX_RETRY      = 3;
  localparam int GAP_CYCLES     = 16;
  localparam int TIMEOUT_CYCLES = 64;

  logic             CLK = 1'b0;
  logic             reset;
  logic             start;
  logic [IDX_W-1:0] lut_addr;
  logic [23:0]      lut_data;
  logic [23:0]      i2c_data;
  logic             i2c_go;
  logic             i2c_end;
  logic             i2c_nack;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] err_index;
  state_e           dbg_state;

  // Independent copy of the expected table contents.
  logic [23:0] rom_tbl [NUM_REGS] = '{24'h34001F, 24'h340217, 24'h340479, 24'h340679};

  // Scenario configuration read by the controller model and the reference model.
  int fail_cnt  [NUM_REGS];   // leading attempts that fail for each entry
  bit fail_kind [NUM_REGS];   // 0: NACK, 1: never end (timeout)
  int att       [NUM_REGS];
  int delay_fixed;            // 0: random 1..63 cycles to end
  bit spurious_en;
  int spacing_exact;          // 0: only check the minimum spacing

  // Scoreboard state.
  logic [23:0] exp_q[$];
  int          exp_total;
  bit          exp_done;
  bit          exp_err;
  int          exp_idx;
  logic [23:0] last_exp_word;
  int          go_seen;
  int          last_go_cyc;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  i2c_config_rom #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rom (
    .CLK  (CLK),
    .addr (lut_addr),
    .data (lut_data)
  );

  i2c_config_sequencer #(
    .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .MAX_RETRY(MAX_RETRY),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .i2c_data  (i2c_data),
    .i2c_go    (i2c_go),
    .i2c_end   (i2c_end),
    .i2c_nack  (i2c_nack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 CLK = ~CLK;

  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int word_index(input logic [23:0] w);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rom_tbl[i] == w) return i;
    end
    return -1;
  endfunction

  // Reference model: every entry gets up to MAX_RETRY+1 attempts; an attempt
  // succeeds unless it is one of the entry's leading failures or the end
  // arrives later than the WAIT_END window allows.
  task automatic build_expect();
    bit ok;
    exp_q.delete();
    exp_total = 0;
    exp_err   = 0;
    exp_idx   = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ok = 0;
      for (int a = 0; a <= MAX_RETRY; a++) begin
        exp_q.push_back(rom_tbl[i]);
        last_exp_word = rom_tbl[i];
        exp_total++;
        if (!(a < fail_cnt[i] || delay_fixed > TIMEOUT_CYCLES - 1)) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        exp_err = 1;
        exp_idx = i;
        break;
      end
    end
    exp_done = !exp_err;
  endtask

  // Behavioural I2C write controller: answers each GO after a delay.
  initial begin
    int  pend;
    bit  pend_nack;
    int  spur;
    int  idx;
    int  d;
    pend = 0; pend_nack = 0; spur = 0;
    i2c_end = 0; i2c_nack = 0;
    forever begin
      @(posedge CLK); #1;
      i2c_end  = 0;
      i2c_nack = 0;
      if (reset) begin
        pend = 0;
        spur = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            i2c_end  = 1;
            i2c_nack = pend_nack;
            if (spurious_en) spur = 3;
          end
        end else if (spur > 0) begin
          spur--;
          if (spur == 0) begin
            i2c_end  = 1;
            i2c_nack = 1;
          end
        end
        if (i2c_go) begin
          idx = word_index(i2c_data);
          d   = (delay_fixed != 0) ? delay_fixed : int'($urandom_range(63, 1));
          if (idx >= 0 && att[idx] < fail_cnt[idx]) begin
            if (fail_kind[idx]) begin
              pend = 0;
            end else begin
              pend      = d;
              pend_nack = 1;
            end
          end else begin
            pend      = d;
            pend_nack = 0;
          end
          if (idx >= 0) att[idx]++;
        end
      end
    end
  end

  // Monitor: pops the expected word on every GO pulse and checks spacing.
  initial begin
    forever begin
      @(negedge CLK);
      if (reset) begin
        last_go_cyc = -1;
      end else if (i2c_go) begin
        go_seen++;
        if (exp_q.size() == 0) begin
          check("go_unexpected", 32'd1, 32'd0);
        end else begin
          check("go_word", i2c_data, exp_q.pop_front());
        end
        if (last_go_cyc >= 0) begin
          if (spacing_exact != 0)
            check("go_spacing", cyc - last_go_cyc, spacing_exact);
          else
            check("go_spacing_min", (cyc - last_go_cyc) >= GAP_CYCLES + 3, 1);
        end
        last_go_cyc = cyc;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_lut_addr",  lut_addr,  0);
    check("rst_i2c_data",  i2c_data,  0);
    check("rst_i2c_go",    i2c_go,    0);
    check("rst_busy",      busy,      0);
    check("rst_done",      done,      0);
    check("rst_error",     error,     0);
    check("rst_err_index", err_index, 0);
    check("rst_state",     dbg_state, S_IDLE);
  endtask

  task automatic setup(input int d, input int spacing, input bit spur);
    for (int i = 0; i < NUM_REGS; i++) begin
      fail_cnt[i]  = 0;
      fail_kind[i] = 0;
      att[i]       = 0;
    end
    delay_fixed   = d;
    spacing_exact = spacing;
    spurious_en   = spur;
  endtask

  // Runs one full sequence from a start pulse and checks the outcome.
  task automatic run_seq(input bit poke);
    bit fin;
    for (int i = 0; i < NUM_REGS; i++) att[i] = 0;
    build_expect();
    go_seen     = 0;
    last_go_cyc = -1;
    @(posedge CLK); #1;
    start = 1;
    @(posedge CLK); #1;
    start = 0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("error_cleared", error, 0);
    check("lut_addr_fetch", lut_addr, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("go_not_early", i2c_go, 0);
    @(posedge CLK); #1;
    check("go_latency", i2c_go, 1);
    fin = 0;
    for (int n = 0; n < 4000 && !fin; n++) begin
      @(posedge CLK); #1;
      start = (poke && n == 60);
      if (poke && n == 60) check("busy_at_poke", busy, 1);
      if (done || error) fin = 1;
    end
    start = 0;
    check("seq_finished", fin, 1);
    repeat (40) @(posedge CLK);
    #1;
    check("go_count", go_seen, exp_total);
    check("exp_q_drained", exp_q.size(), 0);
    check("done", done, exp_done);
    check("error", error, exp_err);
    check("busy_end", busy, 0);
    check("i2c_data_hold", i2c_data, last_exp_word);
    if (exp_err) check("err_index", err_index, exp_idx);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Main stimulus.
  initial begin
    bit reached;
    reset = 1; start = 0;
    setup(30, 51, 0);
    go_seen = 0; last_go_cyc = -1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs();
    reset = 0;

    // All entries acknowledged, end 30 cycles after GO, start poked while busy.
    setup(30, 51, 0);
    run_seq(1);

    // Entry 1 NACKed once, then acknowledged.
    setup(30, 51, 1);
    fail_cnt[1] = 1;
    run_seq(0);

    // Entry 2 always NACKed.
    setup(30, 51, 1);
    fail_cnt[2] = 99;
    run_seq(0);

    // Entry 0 never ends: four timeouts.
    setup(30, 84, 0);
    fail_cnt[0] = 99; fail_kind[0] = 1;
    run_seq(0);

    // End on the last timeout cycle wins over the timeout.
    setup(TIMEOUT_CYCLES - 1, 84, 0);
    run_seq(0);

    // End one cycle too late: treated as a timeout, late end ignored.
    setup(TIMEOUT_CYCLES, 84, 1);
    run_seq(0);

    // Reset while waiting for the end of entry 1.
    setup(30, 51, 0);
    exp_q.delete();
    exp_q.push_back(rom_tbl[0]);
    exp_q.push_back(rom_tbl[1]);
    go_seen = 0; last_go_cyc = -1;
    @(posedge CLK); #1;
    start = 1;
    @(posedge CLK); #1;
    start = 0;
    reached = 0;
    for (int n = 0; n < 500 && !reached; n++) begin
      @(posedge CLK); #1;
      if (go_seen == 2) reached = 1;
    end
    check("reached_entry1", reached, 1);
    repeat (5) @(posedge CLK);
    #1;
    check("in_wait_end", dbg_state, S_WAIT_END);
    check("wait_end_addr", lut_addr, 1);
    reset = 1;
    @(posedge CLK); #1;
    check_reset_outputs();
    reset = 0;
    check("abort_q_drained", exp_q.size(), 0);
    setup(30, 51, 0);
    run_seq(0);

    // Randomised retry patterns.
    for (int r = 0; r < 8; r++) begin
      setup(0, 0, 1);
      for (int i = 0; i < NUM_REGS; i++) begin
        fail_cnt[i]  = $urandom_range(MAX_RETRY + 1, 0);
        fail_kind[i] = 1'($urandom_range(1, 0));
      end
      run_seq(1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
